// File: rtl/instr_word_assembler_if.sv
//------------------------------------------------------------------------------
// Module   : instr_word_assembler_if
// Brief    : Field-set input and packed-word output bundle for the assembler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_word_assembler_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               fmt;
  logic [5:0]               opcode;
  logic [4:0]               rs;
  logic [4:0]               rt;
  logic [4:0]               rd;
  logic [4:0]               shamt;
  logic [5:0]               funct;
  logic [15:0]              immediate;
  logic [25:0]              target;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_word;
  logic [ADDR_W-1:0]        out_addr;
  logic [$clog2(DEPTH):0]   count;
  logic                     fmt_err;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, immediate, target,
    output out_ready,
    input  in_ready, out_valid, out_word, out_addr, count, fmt_err
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, immediate, target,
    input  out_ready,
    output in_ready, out_valid, out_word, out_addr, count, fmt_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_word_assembler.sv
//------------------------------------------------------------------------------
// Module   : instr_word_assembler
// Brief    : Packs MIPS R/I/J fields into 32-bit words, queues them in a FIFO
//            and streams them out with a running word address.
//            Optional macro IWA_FLUSH_EN adds a synchronous flush input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_word_assembler #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef IWA_FLUSH_EN
  input  logic                   flush,
`endif
  instr_word_assembler_if.slave  bus
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]         c_FMT_R = 2'b00;
  localparam logic [1:0]         c_FMT_I = 2'b01;
  localparam logic [1:0]         c_FMT_J = 2'b10;
  localparam logic [1:0]         c_FMT_X = 2'b11;

  logic [31:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_fmt_err;

  logic [31:0]        w_word;
  logic               w_flush;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_in_fire;
  logic               w_push;
  logic               w_pop;

`ifdef IWA_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_word = 32'h0;
    case (bus.fmt)
      c_FMT_R: w_word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      c_FMT_I: w_word = {bus.opcode, bus.rs, bus.rt, bus.immediate};
      c_FMT_J: w_word = {bus.opcode, bus.target};
      default: w_word = 32'h0;
    endcase
  end

  // Ready depends only on registered occupancy, never on out_ready.
  assign w_in_ready  = (r_count != c_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_in_fire   = bus.in_valid && w_in_ready && !w_flush;
  assign w_push      = w_in_fire && (bus.fmt != c_FMT_X);
  assign w_pop       = w_out_valid && bus.out_ready && !w_flush;

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_addr    <= c_BASE;
      r_fmt_err <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_addr    <= c_BASE;
      r_fmt_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_in_fire && (bus.fmt == c_FMT_X)) begin
        r_fmt_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_word  = w_out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign bus.out_addr  = r_addr;
  assign bus.count     = r_count;
  assign bus.fmt_err   = r_fmt_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_word_assembler.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_word_assembler
// Brief    : Directed and random checks of instr_word_assembler against a
//            queue-based reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_word_assembler;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
  localparam int AMOD   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
`ifdef IWA_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  instr_word_assembler_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  instr_word_assembler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef IWA_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [31:0] m_q[$];
  int          m_addr;
  bit          m_err;

  function automatic logic [31:0] pack_word(int f, int op, int rs, int rt, int rd,
                                            int sh, int fn, int imm, int tgt);
    longint w;
    case (f)
      0:       w = op * (2**26) + rs * (2**21) + rt * (2**16) + rd * (2**11) + sh * 64 + fn;
      1:       w = op * (2**26) + rs * (2**21) + rt * (2**16) + imm;
      default: w = op * (2**26) + tgt;
    endcase
    return 32'(w);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready",  32'(bus.in_ready),  32'(m_q.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("count",     32'(bus.count),     32'(m_q.size()));
    chk("fmt_err",   32'(bus.fmt_err),   32'(m_err));
    if (m_q.size() != 0) begin
      chk("out_word", bus.out_word,      m_q[0]);
      chk("out_addr", 32'(bus.out_addr), 32'(m_addr));
    end
  endtask

  task automatic cycle();
    bit          acc_in, acc_out, fl;
    bit          reserved;
    logic [31:0] w;
    acc_in   = bus.in_valid && (m_q.size() != DEPTH);
    acc_out  = bus.out_ready && (m_q.size() != 0);
    reserved = (bus.fmt == 2'b11);
    w = pack_word(int'(bus.fmt), int'(bus.opcode), int'(bus.rs), int'(bus.rt), int'(bus.rd),
                  int'(bus.shamt), int'(bus.funct), int'(bus.immediate), int'(bus.target));
`ifdef IWA_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_addr = 0;
      m_err  = 1'b0;
    end else begin
      if (acc_out) begin
        void'(m_q.pop_front());
        m_addr = (m_addr + 1) % AMOD;
      end
      if (acc_in) begin
        if (reserved) m_err = 1'b1;
        else          m_q.push_back(w);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_fields();
    bus.opcode    = 6'($urandom);
    bus.rs        = 5'($urandom);
    bus.rt        = 5'($urandom);
    bus.rd        = 5'($urandom);
    bus.shamt     = 5'($urandom);
    bus.funct     = 6'($urandom);
    bus.immediate = 16'($urandom);
    bus.target    = 26'($urandom);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
  endtask

  initial begin
    rst_n         = 1'b0;
`ifdef IWA_FLUSH_EN
    flush         = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fmt       = 2'b00;
    rand_fields();
    m_addr = 0;
    m_err  = 1'b0;

    #12;
    chk("rst_out_word", bus.out_word, 32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // R-format pack
    bus.fmt = 2'b00; bus.opcode = 6'd0; bus.rs = 5'd1; bus.rt = 5'd2;
    bus.rd = 5'd3; bus.shamt = 5'd0; bus.funct = 6'h20;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cycle();
    chk("r_word", bus.out_word, 32'h00221820);
    chk("r_addr", 32'(bus.out_addr), 32'd0);
    drain();

    // I then J pack, held until both are queued
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.fmt = 2'b01; bus.opcode = 6'h08; bus.rs = 5'd0; bus.rt = 5'd8; bus.immediate = 16'hFFFF;
    cycle();
    chk("i_word", bus.out_word, 32'h2008FFFF);
    bus.fmt = 2'b10; bus.opcode = 6'd2; bus.target = 26'h0100000;
    cycle();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();
    chk("j_word", bus.out_word, 32'h08100000);
    drain();

    // Full and backpressure
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.fmt = 2'b00;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      cycle();
    end
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    bus.in_valid = 1'b0;
    repeat (5) cycle();

    // Reserved format sets sticky error without writing
    bus.in_valid = 1'b1; bus.fmt = 2'b11; bus.out_ready = 1'b0;
    cycle();
    chk("rsv_count", 32'(bus.count), 32'd0);
    chk("rsv_err", 32'(bus.fmt_err), 32'd1);
    bus.fmt = 2'b01;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      cycle();
    end
    chk("rsv_sticky", 32'(bus.fmt_err), 32'd1);

    // Asynchronous reset with three words queued
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_q.delete();
    m_addr = 0;
    m_err  = 1'b0;
    chk("arst_out_word", bus.out_word, 32'h0);
    chk("arst_count", 32'(bus.count), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef IWA_FLUSH_EN
    bus.in_valid = 1'b1; bus.fmt = 2'b10; bus.out_ready = 1'b0;
    cycle();
    cycle();
    bus.out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_addr", 32'(bus.out_addr), 32'd0);
    bus.in_valid = 1'b0;
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.fmt       = ($urandom_range(0, 31) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
`ifdef IWA_FLUSH_EN
      flush         = ($urandom_range(0, 39) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
